// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter and its picker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rr_mux_arbiter_pkg;

   // Arbiter has no packet in flight (IDLE) or owns one source until its last beat (LOCKED).
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int N_REQ_DEF  = 4;
   localparam int DATA_W_DEF = 8;

   // Width of a requester index (g, ptr); never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: first set request bit scanning upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; result is recomputed every cycle from req and ptr.
//
// Ports:
//   req   - request vector, one bit per source
//   ptr   - index with the highest priority this cycle
//   found - some request bit is set
//   idx   - winning index (0 when found is low)
module rr_priority_pick
   import rr_mux_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic             found,
   output logic [IW-1:0]    idx
);

   // One extra bit so ptr + offset cannot overflow before the modulo fold.
   logic [IW:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      // Walk offsets from farthest to nearest so the nearest hit is the last write.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (IW+1)'(i);
         if (cand >= (IW+1)'(N_REQ)) begin
            cand = cand - (IW+1)'(N_REQ);
         end
         if (req[cand[IW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering an N:1 data mux onto one valid/ready stream, packet-locked.
// Latency: grant one cycle after request in IDLE; datapath combinational while locked; one idle bubble between packets.
// Backpressure: out_ready passes combinationally to req_ready of the granted source only.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_valid/data/last  - per-source beat stream, source i at data bits [i*DATA_W +: DATA_W]
//   req_ready            - per-source ready, at most one bit high
//   out_valid/data/last  - muxed output stream
//   out_ready            - downstream ready
//   grant                - registered one-hot grant, zero when idle
//   busy                 - a grant is held
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   input  logic                      out_ready,
   output logic [N_REQ-1:0]          grant,
   output logic                      busy
);

   localparam int IW = idx_w(N_REQ);

   state_e            state_q, state_d;
   logic [IW-1:0]     g_q, g_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [N_REQ-1:0]  grant_q, grant_d;

   logic              pick_found;
   logic [IW-1:0]     pick_idx;
   logic              locked;
   logic              xfer_last;

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign locked = (state_q == LOCKED);

   // Output mux. Gated by locked so nothing leaks through (and nothing is X) while idle;
   // only the granted source's inputs reach the outputs.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      if (locked) begin
         out_valid = req_valid[g_q];
         out_data  = req_data[int'(g_q)*DATA_W +: DATA_W];
         out_last  = req_last[g_q];
      end
   end

   // grant_q is zero outside LOCKED, so this also masks ready while idle.
   assign req_ready = grant_q & {N_REQ{out_ready}};
   assign grant     = grant_q;
   assign busy      = locked;

   assign xfer_last = out_valid && out_ready && out_last;

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = LOCKED;
               g_d     = pick_idx;
               grant_d = N_REQ'(1) << pick_idx;
            end
         end
         LOCKED: begin
            // Only the final beat releases; a stalled source keeps the lock.
            if (xfer_last) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + IW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one N-to-1 data multiplexer between N packet sources and drives a single valid/ready output stream. It registers a grant, steers the mux select to the granted source, and holds the grant until that source's last beat is accepted. The grant then rotates, so no source can starve another. It sits in front of any shared downstream consumer, such as a serializer or single-port buffer, and is the sequencing layer above the plain mux blocks.

## Interface
Parameters:
- N_REQ, 4, number of requesters; must be ≥2.
- DATA_W, 8, data width per requester.

Ports:
- clk  input  1  rising-edge clock; the only clock domain.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  N_REQ  per-source beat valid.
- req_data  input  N_REQ*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  N_REQ  per-source last-beat-of-packet flag.
- req_ready  output  N_REQ  per-source ready; at most one bit high.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  muxed data from the granted source.
- out_last  output  1  muxed last flag.
- out_ready  input  1  downstream ready.
- grant  output  N_REQ  registered one-hot grant; all zero when idle.
- busy  output  1  high while a grant is held.

## Operation
- There are two states:
  - IDLE: grant = 0.
  - LOCKED: grant is one-hot, index g.
- IDLE → LOCKED when any req_valid is high.
  - Winner is the first set req_valid bit scanning upward from ptr, wrapping modulo N_REQ.
  - grant, g and busy are loaded at the clock edge.
- In LOCKED, the datapath is combinational through the mux selected by g:
  - out_valid = req_valid[g]; out_data = req_data[g]; out_last = req_last[g].
  - req_ready[g] = out_ready; all other req_ready bits are 0.
- A beat transfers on a cycle where out_valid && out_ready.
- LOCKED → IDLE on a transfer with out_last = 1. On that edge, ptr ← (g+1) mod N_REQ.
- If the granted source drops req_valid mid-packet:
  - The grant is held and out_valid = 0.
  - Other requesters are not considered until the last beat of the granted packet transfers.
- Changes to req_valid of non-granted sources while LOCKED have no effect.
- A single-beat packet (last = 1 on the first beat) is legal and releases the grant after that one beat.
- ptr changes only on packet completion. Arbitration in IDLE does not move it.

## Timing
- Reset values: state = IDLE, ptr = 0, grant = 0, busy = 0, req_ready = 0, out_valid = 0. out_data and out_last are don't-care while out_valid = 0 but must not be X when grant = 0; drive 0.
- rst asserted mid-packet: at the next edge the block enters IDLE with ptr = 0. The partial packet is abandoned, with no further ready to the source.
- Arbitration latency: req_valid high in cycle t while IDLE → grant and req_ready are valid in cycle t+1. The first transfer can occur in cycle t+1.
- Release: a last-beat transfer in cycle k → grant = 0 in cycle k+1. The next grant appears in cycle k+2. There is exactly one idle bubble between packets.
- No combinational path from req_valid of a non-granted source to any output.
- out_ready → req_ready[g] is combinational, with zero latency.

## Structure
- The shared package holds:
  - the state enum (IDLE, LOCKED);
  - default constants for N_REQ and DATA_W;
  - a clog2-based index width for g and ptr.
- One sub-module, rr_priority_pick. It is combinational and takes an N_REQ-wide request vector plus ptr. It returns a found flag and a winning index, and is reusable by other arbiters.
- The data mux is an indexed part-select on g inside the top module. It is not a separate instance.

## Test plan
- Reset: hold rst for 2 cycles with all req_valid = 1 → grant = 0, req_ready = 0, out_valid = 0 throughout. The first grant after release is to source 0.
- Rotation:
  - Stimulus: all 4 sources send one-beat packets continuously, out_ready = 1.
  - Required response: grant order 0, 1, 2, 3, 0…
  - One transfer every 2 cycles.
- Lock:
  - Stimulus: source 2 sends a 3-beat packet (data 0xA0, 0xA1, 0xA2) and drops valid for 2 cycles after the first beat; source 1 requests throughout.
  - Required response: grant stays on source 2 until 0xA2 transfers with last = 1. The next grant goes to source 3 if it is requesting, else source 0, else source 1.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles mid-packet.
  - Required response: out_data stable, req_ready[g] = 0, no beat lost or duplicated.
- Sparse:
  - Stimulus: only source 3 requests, sending 2 packets back-to-back.
  - Required response: both are granted to source 3, with one idle cycle between them.
- Reset mid-packet:
  - Stimulus: assert rst during beat 2 of a 4-beat packet from source 1.
  - Required response: IDLE next cycle with ptr = 0.
  - With sources 0 and 1 both requesting after reset, source 0 wins.
